// File: rtl/mips_hazard_pkg.sv
// rtl/mips_hazard_pkg.sv - shared forwarding encodings and Tuse/Tnew constants
package mips_hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_E  = 2'd1,
        FWD_M  = 2'd2
    } fwd_sel_e;

    localparam int TUSE_D    = 0;
    localparam int TUSE_E    = 1;
    localparam int TUSE_M    = 2;

    localparam int TNEW_LINK = 0;
    localparam int TNEW_ALU  = 1;
    localparam int TNEW_LOAD = 2;

    // Width needed to hold a latency count of 0..max_val.
    function automatic int lat_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/md_busy_timer.sv
// rtl/md_busy_timer.sv - multiply/divide unit busy countdown
module md_busy_timer
    import mips_hazard_pkg::*;
#(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic div,
    output logic busy
);

    localparam int BW = lat_width(MULT_LAT, DIV_LAT);

    logic [BW-1:0] busy_cnt;

    // Load the latency when an MD op leaves E, otherwise count down to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_cnt <= '0;
        end else if (start) begin
            busy_cnt <= div ? BW'(DIV_LAT) : BW'(MULT_LAT);
        end else if (busy_cnt != '0) begin
            busy_cnt <= busy_cnt - 1'b1;
        end
    end

    assign busy = (busy_cnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - Tuse/Tnew stall, forwarding and MD interlock for the D stage
module hazard_ctrl
    import mips_hazard_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int T_W      = 2,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rs_d,
    input  logic [REG_AW-1:0] rt_d,
    input  logic              use_rs_d,
    input  logic              use_rt_d,
    input  logic [T_W-1:0]    tuse_rs_d,
    input  logic [T_W-1:0]    tuse_rt_d,
    input  logic [REG_AW-1:0] dst_d,
    input  logic [T_W-1:0]    tnew_d,
    input  logic              md_use_d,
    input  logic              md_start_d,
    input  logic              md_div_d,
    output logic              stall,
    output logic [1:0]        fwd_rs_sel_d,
    output logic [1:0]        fwd_rt_sel_d,
    output logic              md_busy,
    output logic [2:0]        stall_cause,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Shadow copy of the instructions sitting in E and M.
    logic [REG_AW-1:0] dst_e;
    logic [T_W-1:0]    tnew_e;
    logic              start_e;
    logic              div_e;
    logic [REG_AW-1:0] dst_m;
    logic [T_W-1:0]    tnew_m;

    logic hz_rs;
    logic hz_rt;
    logic hz_md;

    // Returns {hazard, fwd_sel} for one source operand. An E match shadows M
    // because E holds the younger writer; W is covered by the RF bypass.
    function automatic logic [2:0] src_check(
        input logic [REG_AW-1:0] src,
        input logic              use_src,
        input logic [T_W-1:0]    tuse,
        input logic [REG_AW-1:0] d_e,
        input logic [T_W-1:0]    t_e,
        input logic [REG_AW-1:0] d_m,
        input logic [T_W-1:0]    t_m
    );
        logic     hit_e;
        logic     hit_m;
        logic     hz;
        fwd_sel_e sel;
        hit_e = use_src && (src != '0) && (src == d_e);
        hit_m = use_src && (src != '0) && (src == d_m);
        hz    = (hit_e && (tuse < t_e)) || (hit_m && (tuse < t_m));
        if (hit_e) begin
            sel = (t_e == '0) ? FWD_E : FWD_RF;
        end else if (hit_m && (t_m == '0)) begin
            sel = FWD_M;
        end else begin
            sel = FWD_RF;
        end
        return {hz, sel};
    endfunction

    // Per-operand data hazards and forwarding selects.
    always_comb begin
        {hz_rs, fwd_rs_sel_d} = src_check(rs_d, use_rs_d, tuse_rs_d,
                                          dst_e, tnew_e, dst_m, tnew_m);
        {hz_rt, fwd_rt_sel_d} = src_check(rt_d, use_rt_d, tuse_rt_d,
                                          dst_e, tnew_e, dst_m, tnew_m);
    end

    // An MD instruction in D waits while the unit counts down or an op is in E.
    assign hz_md       = md_use_d && (md_busy || start_e);
    assign stall       = hz_rs | hz_rt | hz_md;
    assign stall_cause = {hz_md, hz_rt, hz_rs};

    // E/M shadow slots advance every cycle; a stall injects a bubble into E.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dst_e   <= '0;
            tnew_e  <= '0;
            start_e <= 1'b0;
            div_e   <= 1'b0;
            dst_m   <= '0;
            tnew_m  <= '0;
        end else begin
            if (stall) begin
                dst_e   <= '0;
                tnew_e  <= '0;
                start_e <= 1'b0;
                div_e   <= 1'b0;
            end else begin
                dst_e   <= dst_d;
                tnew_e  <= tnew_d;
                start_e <= md_start_d;
                div_e   <= md_div_d;
            end
            dst_m  <= dst_e;
            tnew_m <= (tnew_e == '0) ? '0 : tnew_e - 1'b1;
        end
    end

    // Saturating count of cycles spent stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    md_busy_timer #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_md_busy_timer (
        .clk   (clk),
        .reset (reset),
        .start (start_e),
        .div   (div_e),
        .busy  (md_busy)
    );

endmodule
